adc_req_arbiter: RTL and testbench

ADC_REQ_ARBITER -- requirements
Module: adc_req_arbiter

---
 rtl/adc_req_arbiter_pkg.sv | 26 ++
 rtl/adc_req_arbiter_if.sv | 27 ++
 rtl/adc_req_arbiter_rr_arbiter.sv | 48 ++++
 rtl/adc_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adc_req_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_req_arbiter_pkg.sv
// Shared types and constants for the ADC request arbiter.
package adc_pkg;

    localparam int unsigned ADC_W    = 12;
    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned CH_W     = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_CONV,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADC_W-1:0] data;
        logic [CH_W-1:0]  ch;
    } result_t;

    // Round-robin successor of a requester index among n requesters.
    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] idx,
                                                 input int unsigned     n);
        return (idx == CH_W'(n - 1)) ? '0 : idx + CH_W'(1);
    endfunction

endpackage

// File: rtl/adc_req_arbiter_if.sv
// Requester, converter and result signals of the ADC request arbiter.
interface adc_req_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import adc_pkg::*;

    logic [NREQ-1:0]  req_i;
    logic [NREQ-1:0]  grant_o;
    logic             adc_data_req_o;
    logic             adc_data_rdy_i;
    logic [ADC_W-1:0] adc_data_i;
    logic [ADC_W-1:0] data_o;
    logic [CH_W-1:0]  ch_o;
    logic             data_rdy_o;
    logic             err_o;

    modport master (
        input  req_i, adc_data_rdy_i, adc_data_i,
        output grant_o, adc_data_req_o, data_o, ch_o, data_rdy_o, err_o
    );

    modport slave (
        output req_i, adc_data_rdy_i, adc_data_i,
        input  grant_o, adc_data_req_o, data_o, ch_o, data_rdy_o, err_o
    );

endinterface

// File: rtl/adc_req_arbiter_rr_arbiter.sv
// Round-robin requester pick; search starts one past the last granted index.
module rr_arbiter
    import adc_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant_c,
    output logic [CH_W-1:0] idx_c
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned POS_W = CH_W + 1;

    logic [CH_W-1:0]  ptr;
    logic [POS_W-1:0] pos;
    logic             found;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + POS_W'(i);
            if (pos >= POS_W'(NREQ)) begin
                pos = pos - POS_W'(NREQ);
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                found                   = 1'b1;
                grant_c[pos[PTR_W-1:0]] = 1'b1;
                idx_c                   = pos[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= next_idx(idx_c, NREQ);
        end
    end

endmodule

// File: rtl/adc_req_arbiter.sv
// Shares one ADC among NREQ requesters and averages 2^NAVG_LOG2 samples per grant.
// Optional watchdog on missing sample strobes: define ADC_TIMEOUT_EN.
module adc_req_arbiter
    import adc_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned NAVG_LOG2 = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    adc_req_arbiter_if.master bus
);

    localparam int unsigned ACC_W = ADC_W + NAVG_LOG2;
    localparam int unsigned CNT_W = NAVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] NSAMP = CNT_W'(2 ** NAVG_LOG2);

    if (NREQ < 2 || NREQ > MAX_NREQ || NAVG_LOG2 > 4 || TIMEOUT < 1) begin : g_bad_param
        $error("adc_req_arbiter: parameter out of range");
    end

    state_t          state;
    logic [NREQ-1:0] grant_q;
    logic [CH_W-1:0] idx_q;
    logic            adc_req_q;
    logic            data_rdy_q;
    result_t         res_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             rdy_q;

    logic             strobe_c;
    logic             arb_en_c;
    logic [ACC_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic [NREQ-1:0]  arb_grant_c;
    logic [CH_W-1:0]  arb_idx_c;

    assign strobe_c  = rdy_q && !bus.adc_data_rdy_i;
    assign arb_en_c  = (state == S_IDLE) && (|bus.req_i);
    assign sum_c     = acc + ACC_W'(bus.adc_data_i);
    assign cnt_nxt_c = cnt + CNT_W'(1);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk     (clk_i),
        .rst     (reset_i),
        .req     (bus.req_i),
        .en      (arb_en_c),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c)
    );

    // Falling-edge detect of the converter ready line.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= bus.adc_data_rdy_i;
        end
    end

`ifdef ADC_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            err_q;
    logic            busy_c;
    logic            timeout_c;

    assign busy_c    = (state == S_GRANT) || (state == S_CONV);
    assign timeout_c = busy_c && !((state == S_CONV) && strobe_c)
                       && (wd == WD_W'(TIMEOUT - 1));

    // Cycles spent in GRANT/CONV since the grant or the last counted strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd <= '0;
        end else if (arb_en_c || ((state == S_CONV) && strobe_c)) begin
            wd <= '0;
        end else if (busy_c) begin
            wd <= wd + WD_W'(1);
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            adc_req_q  <= 1'b0;
            data_rdy_q <= 1'b0;
            res_q      <= '0;
            acc        <= '0;
            cnt        <= '0;
`ifdef ADC_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            data_rdy_q <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_en_c) begin
                        state     <= S_GRANT;
                        grant_q   <= arb_grant_c;
                        idx_q     <= arb_idx_c;
                        adc_req_q <= 1'b1;
                    end
                end
                S_GRANT: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= S_CONV;
                end
                S_CONV: begin
                    if (strobe_c) begin
                        acc <= sum_c;
                        cnt <= cnt_nxt_c;
                        // Final sample is folded in here so the result appears in DONE.
                        if (cnt_nxt_c == NSAMP) begin
                            state      <= S_DONE;
                            adc_req_q  <= 1'b0;
                            res_q.data <= ADC_W'(sum_c >> NAVG_LOG2);
                            res_q.ch   <= idx_q;
                            data_rdy_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
`ifdef ADC_TIMEOUT_EN
            if (timeout_c) begin
                state     <= S_IDLE;
                grant_q   <= '0;
                adc_req_q <= 1'b0;
                res_q.ch  <= idx_q;
                err_q     <= 1'b1;
            end
`endif
        end
    end

    assign bus.grant_o        = grant_q;
    assign bus.adc_data_req_o = adc_req_q;
    assign bus.data_o         = res_q.data;
    assign bus.ch_o           = res_q.ch;
    assign bus.data_rdy_o     = data_rdy_q;

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Scoreboard bench for adc_req_arbiter (NREQ=4, NAVG_LOG2=3, TIMEOUT=20).
module tb_adc_req_arbiter;
    import adc_pkg::*;

    localparam int unsigned NREQ = 4;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_req_arbiter_if #(.NREQ(NREQ)) bus ();

    adc_req_arbiter #(
        .NREQ      (NREQ),
        .NAVG_LOG2 (3),
        .TIMEOUT   (20)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_pulses = 0;
    int   err_pulses = 0;
    int   rr_ptr = 0;
    exp_t sb[$];

    // Result monitor: pops the scoreboard on every data_rdy_o pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.data_rdy_o === 1'b1) begin
            rdy_pulses++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: data_rdy_o with data=%0d ch=%0d, nothing expected",
                         bus.data_o, bus.ch_o);
            end else begin
                e = sb.pop_front();
                if (bus.data_o !== e.data || bus.ch_o !== e.ch) begin
                    n_err++;
                    $display("FAIL sb_result: got data=%0d ch=%0d, expected data=%0d ch=%0d",
                             bus.data_o, bus.ch_o, e.data, e.ch);
                end
            end
        end
        if (!rst && bus.err_o === 1'b1) err_pulses++;
    end

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic send(input logic [11:0] v);
        bus.adc_data_rdy_i = 1'b1;
        bus.adc_data_i     = v;
        @(posedge clk); #1;
        bus.adc_data_rdy_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.grant_o != '0) ok = 1'b1;
        end
    endtask

    // Grant, then eight samples base, base+step, ...; returns in the cycle after the last strobe.
    task automatic run_conv(input int base, input int step, output bit ok,
                            output logic [3:0] gnt, output logic rdy_after);
        gnt = '0;
        rdy_after = 1'b0;
        wait_grant(ok);
        if (!ok) return;
        gnt = bus.grant_o;
        for (int i = 0; i < 8; i++) send(12'(base + i * step));
        rdy_after = bus.data_rdy_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = '0;
        bus.adc_data_rdy_i = 1'b0;
        bus.adc_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.grant_o !== 4'b0 || bus.adc_data_req_o !== 1'b0 || bus.data_o !== 12'd0 ||
            bus.ch_o !== 3'd0 || bus.data_rdy_o !== 1'b0 || bus.err_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: grant=%b req=%b data=%0d ch=%0d rdy=%b err=%b, expected all 0",
                     bus.grant_o, bus.adc_data_req_o, bus.data_o, bus.ch_o, bus.data_rdy_o, bus.err_o);
        end
        rst = 1'b0;
        rr_ptr = 0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.grant_o !== 4'b0 || bus.adc_data_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: grant=%b adc_req=%b with no request, expected 0/0",
                     bus.grant_o, bus.adc_data_req_o);
        end
    endtask

    task automatic test_round_robin();
        bit ok; logic [3:0] gnt; logic rdy; int idx;
        bus.req_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            idx = rr_pick(4'b1111, rr_ptr);
            rr_ptr = (idx + 1) % 4;
            sb.push_back('{data: 12'(((8 * (40 * c)) + 84) >> 3), ch: 3'(idx)});
            run_conv(40 * c, 3, ok, gnt, rdy);
            if (c == 4) bus.req_i = '0;
            n_vec++;
            if (!ok || gnt !== 4'(1 << idx) || rdy !== 1'b1) begin
                n_err++;
                $display("FAIL rr_grant_%0d: granted=%b got=%b rdy=%b, expected grant %b rdy 1",
                         c, ok, gnt, rdy, 4'(1 << idx));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok; logic [3:0] gnt; logic rdy; int idx;
        bus.req_i = 4'b0001;
        idx = rr_pick(4'b0001, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        sb.push_back('{data: 12'd103, ch: 3'd0});
        wait_grant(ok);
        n_vec++;
        if (!ok || bus.grant_o !== 4'b0001 || bus.adc_data_req_o !== 1'b1) begin
            n_err++;
            $display("FAIL basic_grant: grant=%b adc_req=%b, expected 0001/1",
                     bus.grant_o, bus.adc_data_req_o);
        end
        for (int i = 0; i < 8; i++) send(12'(100 + i));
        rdy = bus.data_rdy_o;
        n_vec++;
        if (rdy !== 1'b1 || bus.adc_data_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_latency: data_rdy=%b adc_req=%b one cycle after last strobe, expected 1/0",
                     rdy, bus.adc_data_req_o);
        end
        bus.req_i = '0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.data_rdy_o !== 1'b0 || bus.data_o !== 12'd103 || bus.ch_o !== 3'd0 || bus.grant_o !== 4'b0) begin
            n_err++;
            $display("FAIL basic_hold: rdy=%b data=%0d ch=%0d grant=%b, expected 0/103/0/0000",
                     bus.data_rdy_o, bus.data_o, bus.ch_o, bus.grant_o);
        end
    endtask

    task automatic test_full_scale();
        bit ok; logic [3:0] gnt; logic rdy; int idx;
        bus.req_i = 4'b0100;
        idx = rr_pick(4'b0100, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        sb.push_back('{data: 12'd4095, ch: 3'(idx)});
        run_conv(4095, 0, ok, gnt, rdy);
        bus.req_i = '0;
        n_vec++;
        if (!ok || gnt !== 4'b0100 || rdy !== 1'b1) begin
            n_err++;
            $display("FAIL full_scale: granted=%b grant=%b rdy=%b, expected 0100 rdy 1", ok, gnt, rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drop_req();
        bit ok; int idx; int p0;
        bus.req_i = 4'b1000;
        idx = rr_pick(4'b1000, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        sb.push_back('{data: 12'((8 * 500 + 8 * 7 * 2 / 2) >> 3), ch: 3'(idx)});
        p0 = rdy_pulses;
        wait_grant(ok);
        for (int i = 0; i < 8; i++) begin
            send(12'(500 + 2 * i));
            if (i == 2) bus.req_i = '0;
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (!ok || rdy_pulses - p0 !== 1 || bus.grant_o !== 4'b0) begin
            n_err++;
            $display("FAIL drop_req: granted=%b pulses=%0d grant=%b, expected 1 pulse then idle",
                     ok, rdy_pulses - p0, bus.grant_o);
        end
    endtask

    task automatic test_grant_strobe();
        bit ok; int idx;
        bus.req_i = 4'b0010;
        bus.adc_data_rdy_i = 1'b1;
        bus.adc_data_i = 12'd4000;
        idx = rr_pick(4'b0010, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        sb.push_back('{data: 12'd60, ch: 3'(idx)});
        wait_grant(ok);
        bus.adc_data_rdy_i = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(12'd60);
        bus.req_i = '0;
        n_vec++;
        if (!ok || bus.data_rdy_o !== 1'b1) begin
            n_err++;
            $display("FAIL grant_strobe: granted=%b rdy=%b after 8 strobes in CONV, expected rdy 1",
                     ok, bus.data_rdy_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok; int p0; int e0; int idx;
        bus.req_i = 4'b0001;
        wait_grant(ok);
        for (int i = 0; i < 5; i++) send(12'd900);
        p0 = rdy_pulses;
        e0 = err_pulses;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.grant_o !== 4'b0 || bus.adc_data_req_o !== 1'b0 || bus.data_o !== 12'd0 ||
            bus.ch_o !== 3'd0 || bus.data_rdy_o !== 1'b0 || bus.err_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: grant=%b req=%b data=%0d ch=%0d rdy=%b err=%b, expected all 0",
                     bus.grant_o, bus.adc_data_req_o, bus.data_o, bus.ch_o, bus.data_rdy_o, bus.err_o);
        end
        bus.req_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        bus.req_i = 4'b0010;
        idx = rr_pick(4'b0010, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        sb.push_back('{data: 12'd20, ch: 3'(idx)});
        wait_grant(ok);
        for (int i = 0; i < 7; i++) send(12'd20);
        n_vec++;
        if (!ok || bus.data_rdy_o !== 1'b0 || rdy_pulses != p0 || err_pulses != e0) begin
            n_err++;
            $display("FAIL reset_restart: granted=%b rdy=%b pulses=%0d errs=%0d after 7 samples, expected 0/0/0",
                     ok, bus.data_rdy_o, rdy_pulses - p0, err_pulses - e0);
        end
        send(12'd20);
        bus.req_i = '0;
        n_vec++;
        if (bus.data_rdy_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_restart_done: rdy=%b after 8th sample, expected 1", bus.data_rdy_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok; logic [3:0] gnt; logic rdy; int i0; int i1;
        bus.req_i = 4'b0011;
        i0 = rr_pick(4'b0011, rr_ptr);
        i1 = rr_pick(4'b0011, (i0 + 1) % 4);
        rr_ptr = (i1 + 1) % 4;
        sb.push_back('{data: 12'((8 * 200 + 84) >> 3), ch: 3'(i0)});
        sb.push_back('{data: 12'((8 * 300 + 84) >> 3), ch: 3'(i1)});
        run_conv(200, 3, ok, gnt, rdy);
        @(posedge clk); #1;
        n_vec++;
        if (!ok || gnt !== 4'(1 << i0) || bus.grant_o !== 4'b0 || bus.adc_data_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: first=%b idle grant=%b adc_req=%b, expected first %b then 0000/0",
                     gnt, bus.grant_o, bus.adc_data_req_o, 4'(1 << i0));
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.grant_o !== 4'(1 << i1)) begin
            n_err++;
            $display("FAIL b2b_second: grant=%b, expected %b", bus.grant_o, 4'(1 << i1));
        end
        bus.req_i = '0;
        run_conv(300, 3, ok, gnt, rdy);
        n_vec++;
        if (!ok || rdy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done: granted=%b rdy=%b, expected 1/1", ok, rdy);
        end
        @(posedge clk); #1;
    endtask

`ifdef ADC_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int n; int p0; int idx;
        bus.req_i = 4'b0100;
        idx = rr_pick(4'b0100, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        p0 = rdy_pulses;
        wait_grant(ok);
        n = 0;
        while (bus.err_o !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bus.req_i = '0;
        n_vec++;
        if (!ok || n != 20 || bus.adc_data_req_o !== 1'b0 || bus.grant_o !== 4'b0 || bus.ch_o !== 3'(idx)) begin
            n_err++;
            $display("FAIL timeout: err after %0d cycles adc_req=%b grant=%b ch=%0d, expected 20/0/0000/%0d",
                     n, bus.adc_data_req_o, bus.grant_o, bus.ch_o, idx);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.err_o !== 1'b0 || rdy_pulses != p0) begin
            n_err++;
            $display("FAIL timeout_pulse: err=%b rdy pulses=%0d next cycle, expected 0/0",
                     bus.err_o, rdy_pulses - p0);
        end
    endtask
`else
    task automatic test_timeout();
        bit ok; int idx; int e0;
        bus.req_i = 4'b0100;
        idx = rr_pick(4'b0100, rr_ptr);
        rr_ptr = (idx + 1) % 4;
        e0 = err_pulses;
        sb.push_back('{data: 12'd7, ch: 3'(idx)});
        wait_grant(ok);
        repeat (300) @(posedge clk);
        #1;
        n_vec++;
        if (!ok || bus.adc_data_req_o !== 1'b1 || bus.grant_o !== 4'b0100 || err_pulses != e0) begin
            n_err++;
            $display("FAIL no_timeout: adc_req=%b grant=%b errs=%0d after 300 idle cycles, expected 1/0100/0",
                     bus.adc_data_req_o, bus.grant_o, err_pulses - e0);
        end
        for (int i = 0; i < 8; i++) send(12'd7);
        bus.req_i = '0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        int exp_errs;
        test_reset();
        test_round_robin();
        test_basic();
        test_full_scale();
        test_drop_req();
        test_grant_strobe();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        repeat (4) @(posedge clk);
        #1;
`ifdef ADC_TIMEOUT_EN
        exp_errs = 1;
`else
        exp_errs = 0;
`endif
        n_vec++;
        if (sb.size() != 0 || err_pulses != exp_errs) begin
            n_err++;
            $display("FAIL end_state: %0d results outstanding, %0d err pulses, expected 0 and %0d",
                     sb.size(), err_pulses, exp_errs);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
